// File: rtl/ysyx_22050598_trap_ctrl_pkg.sv
// Trap sequencer shared constants: CSR addresses, cause codes,
// mstatus bit positions, exc_type encodings and FSM states.
package ysyx_22050598_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [63:0] DEF_CAUSE_ECALL   = 64'hb;
  localparam logic [63:0] DEF_CAUSE_EBREAK  = 64'h3;
  localparam logic [63:0] DEF_CAUSE_ILLEGAL = 64'h2;
  localparam logic [63:0] DEF_CAUSE_MTI     =
    64'h8000_0000_0000_0007;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  localparam logic [1:0] EXC_ECALL   = 2'b00;
  localparam logic [1:0] EXC_MRET    = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL = 2'b10;
  localparam logic [1:0] EXC_EBREAK  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_STATUS = 3'd3,
    ST_REDIRECT = 3'd4
  } state_e;

endpackage

// File: rtl/ysyx_22050598_trap_ctrl.sv
// Trap sequencer between EX and the M-mode CSR file.
// Ports: exc_* request in, commit/irq interrupt inputs, csr_* read values
// in, one CSR write port out, flush pulse, redirect valid/ready, busy.
module ysyx_22050598_trap_ctrl
  import ysyx_22050598_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] CAUSE_ECALL =
    XLEN'(DEF_CAUSE_ECALL),
  parameter logic [XLEN-1:0] CAUSE_EBREAK =
    XLEN'(DEF_CAUSE_EBREAK),
  parameter logic [XLEN-1:0] CAUSE_ILLEGAL =
    XLEN'(DEF_CAUSE_ILLEGAL),
  parameter logic [XLEN-1:0] CAUSE_MTI =
    XLEN'(DEF_CAUSE_MTI)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid_i,
  input  logic [1:0]      exc_type_i,
  input  logic [XLEN-1:0] exc_pc_i,
  output logic            exc_ready_o,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_next_pc_i,
  input  logic            irq_mtip_i,
  input  logic            mie_mtie_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            busy_o
);

  state_e          r_state;
  state_e          w_nstate;
  logic            r_is_mret;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_target;

  logic            w_idle;
  logic            w_take_exc;
  logic            w_take_irq;
  logic            w_accept;
  logic            w_is_mret;
  logic [XLEN-1:0] w_exc_cause;
  logic [XLEN-1:0] w_mst_new;
  logic            w_unused;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_is_mret  = (exc_type_i == EXC_MRET);
  assign w_take_exc = w_idle & exc_valid_i;
  assign w_take_irq = w_idle & irq_mtip_i
                    & mie_mtie_i
                    & csr_mstatus_i[MST_MIE]
                    & commit_valid_i
                    & ~exc_valid_i;
  assign w_accept   = w_take_exc | w_take_irq;

  assign exc_ready_o = w_idle;
  assign busy_o      = ~w_idle;
  assign flush_o     = w_accept & ~rst;

  assign w_unused = &{1'b0, csr_mtvec_i[1:0], r_epc[1:0]};

  always_comb begin
    w_exc_cause = '0;
    unique case (exc_type_i)
      EXC_ECALL:   w_exc_cause = CAUSE_ECALL;
      EXC_ILLEGAL: w_exc_cause = CAUSE_ILLEGAL;
      EXC_EBREAK:  w_exc_cause = CAUSE_EBREAK;
      default:     w_exc_cause = '0;
    endcase
  end

  // mstatus update: trap stacks MIE into MPIE, mret pops it back.
  always_comb begin
    w_mst_new = csr_mstatus_i;
    if (r_is_mret) begin
      w_mst_new[MST_MIE]  = csr_mstatus_i[MST_MPIE];
      w_mst_new[MST_MPIE] = 1'b1;
    end else begin
      w_mst_new[MST_MPIE] = csr_mstatus_i[MST_MIE];
      w_mst_new[MST_MIE]  = 1'b0;
    end
    w_mst_new[MST_MPP_HI:MST_MPP_LO] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_is_mret <= 1'b0;
      r_epc     <= '0;
      r_cause   <= '0;
      r_target  <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_accept) begin
        r_is_mret <= w_take_exc & w_is_mret;
        r_epc     <= w_take_exc ? exc_pc_i
                                : commit_next_pc_i;
        r_cause   <= w_take_exc ? w_exc_cause
                                : CAUSE_MTI;
      end
      // Vectored mtvec is treated as direct.
      if (r_state == ST_W_STATUS) begin
        r_target <= r_is_mret ? csr_mepc_i
                  : {csr_mtvec_i[XLEN-1:2], 2'b00};
      end
    end
  end

  always_comb begin
    w_nstate         = r_state;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_take_exc) begin
          w_nstate = w_is_mret ? ST_W_STATUS
                               : ST_W_EPC;
        end else if (w_take_irq) begin
          w_nstate = ST_W_EPC;
        end
      end
      ST_W_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = {r_epc[XLEN-1:2], 2'b00};
        w_nstate    = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = r_cause;
        w_nstate    = ST_W_STATUS;
      end
      ST_W_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = w_mst_new;
        w_nstate    = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = r_target;
        if (redirect_ready_i) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050598_trap_ctrl.sv
// Scoreboard bench for the trap sequencer: stimulus queues expected
// CSR writes, flushes, redirects and status probes; a monitor checks.
module tb_ysyx_22050598_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid_i;
  logic [1:0]  exc_type_i;
  logic [63:0] exc_pc_i;
  logic        exc_ready_o;
  logic        commit_valid_i;
  logic [63:0] commit_next_pc_i;
  logic        irq_mtip_i;
  logic        mie_mtie_i;
  logic [63:0] csr_mstatus_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        busy_o;

  always #5 clk = ~clk;

  ysyx_22050598_trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .exc_valid_i      (exc_valid_i),
    .exc_type_i       (exc_type_i),
    .exc_pc_i         (exc_pc_i),
    .exc_ready_o      (exc_ready_o),
    .commit_valid_i   (commit_valid_i),
    .commit_next_pc_i (commit_next_pc_i),
    .irq_mtip_i       (irq_mtip_i),
    .mie_mtie_i       (mie_mtie_i),
    .csr_mstatus_i    (csr_mstatus_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .csr_we_o         (csr_we_o),
    .csr_waddr_o      (csr_waddr_o),
    .csr_wdata_o      (csr_wdata_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .busy_o           (busy_o)
  );

  localparam int K_FLUSH = 0;
  localparam int K_CSR   = 1;
  localparam int K_REDIR = 2;

  localparam int P_STAT  = 0;
  localparam int P_EMPTY = 1;
  localparam int P_TOUT  = 2;

  localparam logic [63:0] MTI = 64'h8000_0000_0000_0007;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [63:0] data;
    int          lat;
  } ev_t;

  typedef struct {
    int    kind;
    string name;
    logic  rdy;
    logic  bsy;
    logic  we;
    logic  rv;
  } pr_t;

  ev_t exp_q[$];
  pr_t pr_q[$];

  int checks = 0;
  int errors = 0;

  // ---------------- monitor ----------------
  task automatic take(input int k, input logic [11:0] a,
                      input logic [63:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h",
               k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL event got kind=%0d addr=%h data=%h exp kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  initial begin : monitor
    pr_t  p;
    int   cyc;
    logic rv_prev;
    cyc = 0;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pr_q.size() > 0) begin
        p = pr_q.pop_front();
        checks++;
        if (p.kind == P_STAT) begin
          if ({exc_ready_o, busy_o, csr_we_o,
               redirect_valid_o, flush_o} !==
              {p.rdy, p.bsy, p.we, p.rv, 1'b0}) begin
            errors++;
            $display("FAIL %s got rdy/bsy/we/rv/fl=%b%b%b%b%b exp %b%b%b%b0",
                     p.name, exc_ready_o, busy_o, csr_we_o,
                     redirect_valid_o, flush_o,
                     p.rdy, p.bsy, p.we, p.rv);
          end
        end else if (p.kind == P_EMPTY) begin
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d exp 0",
                     p.name, exp_q.size());
          end
        end else begin
          errors++;
          $display("FAIL timeout %s", p.name);
        end
      end
      if (!rst) begin
        if (flush_o) begin
          cyc = 0;
          take(K_FLUSH, 12'h0, 64'h0);
        end else begin
          cyc++;
        end
        if (csr_we_o) begin
          take(K_CSR, csr_waddr_o, csr_wdata_o);
        end else begin
          checks++;
          if (csr_waddr_o !== 12'h0 ||
              csr_wdata_o !== 64'h0) begin
            errors++;
            $display("FAIL idle_bus got addr=%h data=%h exp 0",
                     csr_waddr_o, csr_wdata_o);
          end
        end
        if (redirect_valid_o) begin
          checks++;
          if (exp_q.size() == 0 ||
              exp_q[0].kind != K_REDIR) begin
            errors++;
            $display("FAIL unexpected_redirect pc=%h",
                     redirect_pc_o);
          end else begin
            if (redirect_pc_o !== exp_q[0].data) begin
              errors++;
              $display("FAIL redirect_pc got %h exp %h",
                       redirect_pc_o, exp_q[0].data);
            end
            if (!rv_prev) begin
              checks++;
              if (cyc != exp_q[0].lat) begin
                errors++;
                $display("FAIL latency got %0d exp %0d",
                         cyc, exp_q[0].lat);
              end
            end
            if (redirect_ready_i) void'(exp_q.pop_front());
          end
        end
        rv_prev = redirect_valid_o & ~redirect_ready_i;
      end else begin
        rv_prev = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_ev(input int k, input logic [11:0] a,
                         input logic [63:0] d, input int lat);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  task automatic probe(input string n, input logic r,
                       input logic b, input logic w,
                       input logic v);
    pr_t p;
    p.kind = P_STAT;
    p.name = n;
    p.rdy  = r;
    p.bsy  = b;
    p.we   = w;
    p.rv   = v;
    pr_q.push_back(p);
  endtask

  task automatic pmark(input int k, input string n);
    pr_t p;
    p.kind = k;
    p.name = n;
    p.rdy  = 1'b0;
    p.bsy  = 1'b0;
    p.we   = 1'b0;
    p.rv   = 1'b0;
    pr_q.push_back(p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_trap(input logic [63:0] epc,
                           input logic [63:0] cause,
                           input logic [63:0] mst,
                           input logic [63:0] tgt);
    push_ev(K_FLUSH, 12'h0, 64'h0, 0);
    push_ev(K_CSR, 12'h341, epc, 0);
    push_ev(K_CSR, 12'h342, cause, 0);
    push_ev(K_CSR, 12'h300, mst, 0);
    push_ev(K_REDIR, 12'h0, tgt, 4);
  endtask

  task automatic push_mret(input logic [63:0] mst,
                           input logic [63:0] tgt);
    push_ev(K_FLUSH, 12'h0, 64'h0, 0);
    push_ev(K_CSR, 12'h300, mst, 0);
    push_ev(K_REDIR, 12'h0, tgt, 2);
  endtask

  task automatic send_exc(input logic [1:0] t,
                          input logic [63:0] pc);
    int n;
    n = 0;
    while (!exc_ready_o && n < 20) begin
      step();
      n++;
    end
    if (!exc_ready_o) pmark(P_TOUT, "exc_ready");
    exc_valid_i = 1'b1;
    exc_type_i  = t;
    exc_pc_i    = pc;
    step();
    exc_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 30) begin
      step();
      n++;
    end
    if (busy_o) pmark(P_TOUT, "wait_idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    rst              = 1'b1;
    exc_valid_i      = 1'b0;
    exc_type_i       = 2'b00;
    exc_pc_i         = '0;
    commit_valid_i   = 1'b0;
    commit_next_pc_i = '0;
    irq_mtip_i       = 1'b0;
    mie_mtie_i       = 1'b0;
    csr_mstatus_i    = '0;
    csr_mtvec_i      = '0;
    csr_mepc_i       = '0;
    redirect_ready_i = 1'b0;
    repeat (3) step();
    probe("reset_state", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();

    // ecall
    csr_mtvec_i      = 64'h8000_1001;
    csr_mstatus_i    = 64'h8;
    redirect_ready_i = 1'b1;
    push_trap(64'h8000_0010, 64'hb, 64'h1880,
              64'h8000_1000);
    send_exc(2'b00, 64'h8000_0010);
    probe("ecall_busy", 1'b0, 1'b1, 1'b1, 1'b0);
    wait_idle();
    probe("ecall_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // mret
    csr_mstatus_i = 64'h1880;
    csr_mepc_i    = 64'h8000_0014;
    push_mret(64'h1888, 64'h8000_0014);
    send_exc(2'b01, 64'h8000_0100);
    probe("mret_c1", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    probe("mret_c2", 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();
    step();

    // timer interrupt taken
    csr_mstatus_i = 64'h8;
    push_trap(64'h8000_0020, MTI, 64'h1880,
              64'h8000_1000);
    irq_mtip_i       = 1'b1;
    mie_mtie_i       = 1'b1;
    commit_valid_i   = 1'b1;
    commit_next_pc_i = 64'h8000_0020;
    step();
    commit_valid_i = 1'b0;
    irq_mtip_i     = 1'b0;
    probe("irq_busy", 1'b0, 1'b1, 1'b1, 1'b0);
    wait_idle();
    step();

    // interrupt masked by MIE=0
    csr_mstatus_i  = 64'h0;
    irq_mtip_i     = 1'b1;
    commit_valid_i = 1'b1;
    repeat (3) step();
    probe("irq_masked", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    commit_valid_i = 1'b0;

    // exception and interrupt in the same cycle
    csr_mstatus_i = 64'h8;
    push_trap(64'h8000_0030, 64'h2, 64'h1880,
              64'h8000_1000);
    commit_valid_i   = 1'b1;
    commit_next_pc_i = 64'h8000_0034;
    exc_valid_i      = 1'b1;
    exc_type_i       = 2'b10;
    exc_pc_i         = 64'h8000_0030;
    step();
    exc_valid_i    = 1'b0;
    commit_valid_i = 1'b0;
    wait_idle();
    step();
    csr_mstatus_i = 64'h1880;
    csr_mepc_i    = 64'h8000_0030;
    push_mret(64'h1888, 64'h8000_0030);
    send_exc(2'b01, 64'h8000_1040);
    wait_idle();
    // MIE restored: the pending interrupt is taken now
    push_trap(64'h8000_0038, MTI, 64'h1880,
              64'h8000_1000);
    csr_mstatus_i    = 64'h1888;
    commit_valid_i   = 1'b1;
    commit_next_pc_i = 64'h8000_0038;
    step();
    commit_valid_i = 1'b0;
    irq_mtip_i     = 1'b0;
    wait_idle();
    step();

    // ebreak with redirect_ready held low
    csr_mstatus_i    = 64'h0;
    csr_mtvec_i      = 64'h8000_2000;
    redirect_ready_i = 1'b0;
    push_trap(64'h8000_0040, 64'h3, 64'h1800,
              64'h8000_2000);
    send_exc(2'b11, 64'h8000_0040);
    n = 0;
    while (!redirect_valid_o && n < 10) begin
      step();
      n++;
    end
    if (!redirect_valid_o) pmark(P_TOUT, "redirect");
    exc_valid_i = 1'b1;
    exc_type_i  = 2'b00;
    exc_pc_i    = 64'h8000_0044;
    for (int i = 0; i < 5; i++) begin
      probe("redir_hold", 1'b0, 1'b1, 1'b0, 1'b1);
      step();
    end
    exc_valid_i = 1'b0;
    // back-to-back ecall right after the handshake
    push_trap(64'h8000_0048, 64'hb, 64'h1800,
              64'h8000_2000);
    redirect_ready_i = 1'b1;
    step();
    send_exc(2'b00, 64'h8000_0048);
    wait_idle();
    step();

    // reset while in W_CAUSE
    csr_mstatus_i = 64'h8;
    csr_mtvec_i   = 64'h8000_1001;
    push_ev(K_FLUSH, 12'h0, 64'h0, 0);
    push_ev(K_CSR, 12'h341, 64'h8000_0050, 0);
    push_ev(K_CSR, 12'h342, 64'hb, 0);
    send_exc(2'b00, 64'h8000_0050);
    step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();
    probe("rst_abort", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    probe("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    pmark(P_EMPTY, "scoreboard_empty");
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
